// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ACTIVITY_EN to include the response activity monitor (act_toggles / act_ops).
module alu_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    input  logic [NREQ*3-1:0]       req_op,
    output logic [W-1:0]            alu_a,
    output logic [W-1:0]            alu_b,
    output logic [2:0]              alu_op,
    input  logic [W-1:0]            alu_y,
    input  logic                    alu_carry,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_y,
    output logic                    rsp_carry,
    output logic                    busy,
    input  logic                    act_clr,
    output logic [15:0]             act_toggles,
    output logic [15:0]             act_ops
);

    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_last_grant;
    logic [IW-1:0]  r_grant_id;
    logic [IW-1:0]  w_winner;
    logic           w_any_valid;
    logic           w_accept;
    logic           w_rsp_hs;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        w_winner    = '0;
        w_any_valid = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(r_last_grant) + i) % NREQ;
            if (!w_any_valid && req_valid[IW'(idx)]) begin
                w_any_valid = 1'b1;
                w_winner    = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_rsp_hs    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    req_ready[w_winner] = 1'b1;
                    w_accept            = 1'b1;
                    w_state_nxt         = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // ALU operands only move on acceptance; response payload only moves in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            r_grant_id   <= '0;
            r_last_grant <= IW'(NREQ - 1);
            rsp_valid    <= 1'b0;
            rsp_y        <= '0;
            rsp_carry    <= 1'b0;
            rsp_id       <= '0;
        end else begin
            if (w_accept) begin
                alu_a        <= req_a[32'(w_winner)*W +: W];
                alu_b        <= req_b[32'(w_winner)*W +: W];
                alu_op       <= req_op[32'(w_winner)*3 +: 3];
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
            end
            if (r_state == EXEC) begin
                rsp_y     <= alu_y;
                rsp_carry <= alu_carry;
                rsp_id    <= r_grant_id;
                rsp_valid <= 1'b1;
            end
            if (w_rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_ACTIVITY_EN
    localparam int unsigned HW = $clog2(W + 1);

    logic [W-1:0]  r_prev_y;
    logic [HW-1:0] w_ham;
    logic [16:0]   w_tog_sum;
    logic [16:0]   w_ops_sum;

    always_comb begin
        w_ham     = HW'($countones(rsp_y ^ r_prev_y));
        w_tog_sum = 17'(act_toggles) + 17'(w_ham);
        w_ops_sum = 17'(act_ops) + 17'd1;
    end

    // Saturating counters; clear wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_y    <= '0;
            act_toggles <= '0;
            act_ops     <= '0;
        end else begin
            if (w_rsp_hs) begin
                r_prev_y <= rsp_y;
            end
            if (act_clr) begin
                act_toggles <= '0;
                act_ops     <= '0;
            end else if (w_rsp_hs) begin
                act_toggles <= w_tog_sum[16] ? 16'hFFFF : w_tog_sum[15:0];
                act_ops     <= w_ops_sum[16] ? 16'hFFFF : w_ops_sum[15:0];
            end
        end
    end
`else
    logic w_unused_act_clr;
    assign w_unused_act_clr = act_clr;
    assign act_toggles      = '0;
    assign act_ops          = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed and randomized transactions against a round-robin/ALU reference model.
module tb_alu_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [2:0]        alu_op;
    logic [W-1:0]      alu_y;
    logic              alu_carry;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_y;
    logic              rsp_carry;
    logic              busy;
    logic              act_clr;
    logic [15:0]       act_toggles;
    logic [15:0]       act_ops;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         m_last;
    logic [7:0] m_alu_a;
    logic [7:0] m_prev;
    int         m_tog;
    int         m_ops;

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_carry(rsp_carry),
        .busy(busy),
        .act_clr(act_clr), .act_toggles(act_toggles), .act_ops(act_ops)
    );

    always #5 clk = ~clk;

    // ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, 5..7 pass a.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb {alu_carry, alu_y} = alu_ref(alu_a, alu_b, alu_op);

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (v[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_tog();
`ifdef ALU_ARB_ACTIVITY_EN
        return 32'(m_tog);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_ops();
`ifdef ALU_ARB_ACTIVITY_EN
        return 32'(m_ops);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = NREQ - 1;
        m_alu_a = 8'h00;
        m_prev  = 8'h00;
        m_tog   = 0;
        m_ops   = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        act_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", {8'h0, alu_a, alu_b, 5'h0, alu_op}, 32'd0);
        check("rst_rsp", {21'h0, rsp_id, rsp_y, rsp_carry}, 32'd0);
        check("rst_act", {act_toggles, act_ops}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_a[k*8 +: 8]  = a;
        req_b[k*8 +: 8]  = b;
        req_op[k*3 +: 3] = op;
    endtask

    task automatic randomize_ops();
        for (int k = 0; k < 4; k++) begin
            set_op(k, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
        end
    endtask

    // One arbitration round; entered and left at #1 after a rising edge.
    task automatic run_txn(input logic [3:0] vmask, input logic [3:0] hold, input int stall);
        int         w;
        logic [3:0] exp_rdy;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [2:0] eo;
        logic [8:0] ey;
        int         ham;
        req_valid = vmask;
        rsp_ready = (stall == 0);
        #1;
        w       = rr_pick(vmask, m_last);
        exp_rdy = (w < 0) ? 4'b0000 : 4'(4'b0001 << w);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("idle_busy", 32'(busy), 32'd0);
        if (w < 0) begin
            @(posedge clk); #1;
            check("noreq_busy", 32'(busy), 32'd0);
            check("noreq_alu_hold", 32'(alu_a), 32'(m_alu_a));
            return;
        end
        ea = req_a[w*8 +: 8];
        eb = req_b[w*8 +: 8];
        eo = req_op[w*3 +: 3];
        ey = alu_ref(ea, eb, eo);
        @(posedge clk); #1;
        m_last  = w;
        m_alu_a = ea;
        check("alu_a", 32'(alu_a), 32'(ea));
        check("alu_b", 32'(alu_b), 32'(eb));
        check("alu_op", 32'(alu_op), 32'(eo));
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        req_valid = hold;
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(w));
        check("rsp_y", 32'(rsp_y), 32'(ey[7:0]));
        check("rsp_carry", 32'(rsp_carry), 32'(ey[8]));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp", {23'h0, rsp_id, rsp_y}, {23'h0, 2'(w), ey[7:0]});
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        ham   = $countones(ey[7:0] ^ m_prev);
        m_tog = (m_tog + ham > 65535) ? 65535 : m_tog + ham;
        m_ops = (m_ops + 1 > 65535) ? 65535 : m_ops + 1;
        m_prev = ey[7:0];
        check("hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);
        check("hs_rsp_retain", {23'h0, rsp_id, rsp_y}, {23'h0, 2'(w), ey[7:0]});
        check("act_toggles", 32'(act_toggles), exp_tog());
        check("act_ops", 32'(act_ops), exp_ops());
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        act_clr   = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);

        // Single request from requester 0: 0x0F + 0x01.
        do_reset();
        set_op(0, 8'h0F, 8'h01, 3'd0);
        run_txn(4'b0001, 4'b0000, 0);
        check("single_rsp_y", 32'(rsp_y), 32'h10);

        // All requesters held high: grants rotate 0,1,2,3,0.
        do_reset();
        randomize_ops();
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 4'b1111, 0);
            check("rr_order", 32'(rsp_id), 32'(i % 4));
        end

        // Response held off for five cycles.
        randomize_ops();
        run_txn(4'b1111, 4'b0000, 5);

        // Reset pulsed during EXEC discards the operation.
        randomize_ops();
        req_valid = 4'b0100;
        #1;
        check("pre_rst_ready", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_alu", {8'h0, alu_a, alu_b, 5'h0, alu_op}, 32'd0);
        check("mid_rst_rsp", {20'h0, rsp_valid, rsp_id, rsp_y, rsp_carry}, 32'd0);
        check("mid_rst_act", {act_toggles, act_ops}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_txn(4'b1111, 4'b0000, 0);
        check("post_rst_grant0", 32'(rsp_id), 32'd0);

        // Activity sequence 0x00, 0xFF, 0x0F, then clear.
        do_reset();
        set_op(0, 8'h00, 8'h00, 3'd2);
        run_txn(4'b0001, 4'b0000, 0);
        set_op(0, 8'hFF, 8'h00, 3'd3);
        run_txn(4'b0001, 4'b0000, 1);
        set_op(0, 8'h0F, 8'h00, 3'd0);
        run_txn(4'b0001, 4'b0000, 0);
`ifdef ALU_ARB_ACTIVITY_EN
        check("act_seq_toggles", 32'(act_toggles), 32'd12);
        check("act_seq_ops", 32'(act_ops), 32'd3);
`else
        check("act_off_toggles", 32'(act_toggles), 32'd0);
        check("act_off_ops", 32'(act_ops), 32'd0);
`endif
        act_clr = 1'b1;
        @(posedge clk); #1;
        act_clr = 1'b0;
        m_tog   = 0;
        m_ops   = 0;
        check("act_clr", {act_toggles, act_ops}, 32'd0);

        // Randomized rounds with noise on req_valid while busy.
        for (int i = 0; i < 40; i++) begin
            randomize_ops();
            run_txn(4'($urandom_range(0, 15)), 4'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one ALU (2..8).
REQ-002 Parameter: W, default 8, operand/result width, matching the alu datapath.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept, at most one bit high.
REQ-007 req_a, req_b  input  NREQ*W each  packed operands, requester k at bits [k*W +: W].
REQ-008 req_op  input  NREQ*3  packed opcodes, requester k at [k*3 +: 3].
REQ-009 alu_a, alu_b  output  W each  registered operands driven to the shared alu.
REQ-010 alu_op  output  3  registered opcode driven to the shared alu.
REQ-011 alu_y  input  W; alu_carry  input  1  combinational alu result.
REQ-012 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-013 rsp_id  output  $clog2(NREQ); rsp_y  output  W; rsp_carry  output  1  response payload.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 act_clr  input  1; act_toggles  output  16; act_ops  output  16  activity monitor.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-017 In IDLE, req_ready SHALL be combinationally one-hot on the round-robin winner among req_valid; all-zero if none valid or not IDLE.
REQ-018 Round-robin SHALL search starting at (last_grant+1) mod NREQ, ascending with wrap.
REQ-019 A transfer occurs on a rising edge with req_valid[k] && req_ready[k]: latch operands into alu_a/alu_b/alu_op, record k, last_grant<=k, go EXEC.
REQ-020 In EXEC (one cycle), the block SHALL capture alu_y/alu_carry into rsp_y/rsp_carry, set rsp_id=k, rsp_valid<=1, go RESP.
REQ-021 rsp_valid SHALL first be high in the second cycle after the acceptance edge; minimum issue interval 3 cycles.
REQ-022 In RESP, rsp_valid and payload SHALL be held stable until rsp_ready is high; on that edge rsp_valid<=0, go IDLE.
REQ-023 alu_a/alu_b/alu_op SHALL hold their last values outside acceptance edges (no idle toggling on the ALU inputs).
REQ-024 Opcodes SHALL pass through undecoded; values 5..7 are forwarded unchanged.
REQ-025 req_valid deasserted before acceptance SHALL drop the request with no side effect.
REQ-026 rsp_y/rsp_carry/rsp_id SHALL retain the last response after rsp_valid falls.

Reset
REQ-027 On rst_n low, state SHALL be IDLE immediately and asynchronously.
REQ-028 Reset values: alu_a/alu_b/alu_op=0, rsp_valid=0, rsp_y=0, rsp_carry=0, rsp_id=0, busy=0, act_toggles=0, act_ops=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-029 Reset during EXEC or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-030 Macro ALU_ARB_ACTIVITY_EN SHALL include the activity monitor.
REQ-031 With it defined: on each response handshake, act_toggles += Hamming distance between the new rsp_y and the previous handshaked rsp_y (previous starts at 0), act_ops += 1; both saturate at 16'hFFFF; act_clr high zeroes both synchronously, taking priority over same-cycle increment.
REQ-032 Without it: act_toggles and act_ops SHALL be constant 0, act_clr ignored, and no monitor registers instantiated.

Verification
REQ-033 Single request: req_valid[0], a=8'h0F, b=8'h01, op=0 (bench ALU model: op0=add) -> req_ready[0] one cycle, rsp_valid two cycles after acceptance, rsp_id=0, rsp_y=8'h10, rsp_carry=0.
REQ-034 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; one acceptance every 3 cycles.
REQ-035 rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready all 0, busy=1; rsp_ready high -> IDLE next cycle.
REQ-036 rst_n pulsed low during EXEC -> all outputs at reset values at once, no rsp_valid afterward, next grant goes to requester 0.
REQ-037 With ALU_ARB_ACTIVITY_EN: responses 8'h00, 8'hFF, 8'h0F -> act_toggles 0, 8, 12; act_ops 3; act_clr -> both 0. Without macro -> both read 0 throughout.
